// File: rtl/fft_pingpong_ctrl.sv
// fft_pingpong_ctrl: bank/address controller for a two-bank FFT stage buffer.
//
// The butterfly writes a word pair per cycle into one bank while the next stage
// drains the other bank one word per cycle. The banks are external and read
// combinationally, so read data is valid in the same cycle as rd_addr.
//
// Build option: define FFT_BITREV_EN to drive rd_addr with the bit-reversed read
// count, which gives natural-order output from a decimation-in-frequency stage.
// When it is undefined, rd_addr follows the read count directly.
//
// Ports:
//   clk         rising-edge clock
//   nrst        asynchronous active-low reset
//   flush       synchronous clear of all state except frames_done
//   in_valid    butterfly presents a word pair
//   in_ready    a pair can be accepted this cycle
//   wr_en       one-hot per-bank write enable (writes wr_addr and wr_addr+1)
//   wr_addr     even base address of the pair
//   out_ready   downstream accepts a word
//   out_valid   word at rd_bank/rd_addr is valid
//   rd_bank     bank being read
//   rd_addr     read address
//   out_last    final word of a frame, qualified by out_valid
//   frames_done count of completed frames, wraps at 255
module fft_pingpong_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [1:0]    wr_en,
  output logic [AW-1:0] wr_addr,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          rd_bank,
  output logic [AW-1:0] rd_addr,
  output logic          out_last,
  output logic [7:0]    frames_done
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFill  = 2'd1,
    StFull  = 2'd2,
    StDrain = 2'd3
  } bank_state_e;

  bank_state_e   bank_q [2];
  logic          wr_bank_q;
  logic [AW-1:0] wr_cnt_q;
  logic          rd_bank_q;
  logic [AW-1:0] rd_cnt_q;
  logic [7:0]    frames_done_q;

  bank_state_e wr_state;
  bank_state_e rd_state;
  logic        wr_acc;
  logic        rd_acc;
  logic        wr_end;
  logic        rd_end;

  always_comb begin
    wr_state  = bank_q[wr_bank_q];
    rd_state  = bank_q[rd_bank_q];
    // A bank being written can never be the bank being read: the two
    // qualifying state sets are disjoint, so the handshakes never collide.
    in_ready  = !flush && (wr_state == StEmpty || wr_state == StFill);
    out_valid = !flush && (rd_state == StFull || rd_state == StDrain);
    wr_acc    = in_valid && in_ready;
    rd_acc    = out_valid && out_ready;
    wr_end    = (wr_cnt_q == AW'(DEPTH - 2));
    rd_end    = (rd_cnt_q == AW'(DEPTH - 1));
    wr_en     = 2'b00;
    if (wr_acc) begin
      wr_en = wr_bank_q ? 2'b10 : 2'b01;
    end
    wr_addr     = wr_cnt_q;
    rd_bank     = rd_bank_q;
    out_last    = out_valid && rd_end;
    frames_done = frames_done_q;
  end

`ifdef FFT_BITREV_EN
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < int'(AW); i++) begin
      rd_addr[i] = rd_cnt_q[int'(AW) - 1 - i];
    end
  end
`else
  always_comb begin
    rd_addr = rd_cnt_q;
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bank_q[0]     <= StEmpty;
      bank_q[1]     <= StEmpty;
      wr_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      rd_bank_q     <= 1'b0;
      rd_cnt_q      <= '0;
      frames_done_q <= 8'd0;
    end else if (flush) begin
      // frames_done deliberately survives a flush.
      bank_q[0] <= StEmpty;
      bank_q[1] <= StEmpty;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
    end else begin
      if (wr_acc) begin
        if (wr_state == StEmpty) begin
          bank_q[wr_bank_q] <= StFill;
        end
        // Later assignment wins, so the final pair of a frame lands in FULL.
        if (wr_end) begin
          bank_q[wr_bank_q] <= StFull;
          wr_cnt_q          <= '0;
          wr_bank_q         <= ~wr_bank_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + AW'(2);
        end
      end
      if (rd_acc) begin
        if (rd_state == StFull) begin
          bank_q[rd_bank_q] <= StDrain;
        end
        if (rd_end) begin
          bank_q[rd_bank_q] <= StEmpty;
          rd_cnt_q          <= '0;
          rd_bank_q         <= ~rd_bank_q;
          frames_done_q     <= frames_done_q + 8'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Directed self-checking bench for fft_pingpong_ctrl (DEPTH=64, AW=6).
// Expected read addresses follow FFT_BITREV_EN when it is defined.
module tb_fft_pingpong_ctrl;

  logic       clk;
  logic       nrst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] wr_en;
  logic [5:0] wr_addr;
  logic       out_ready;
  logic       out_valid;
  logic       rd_bank;
  logic [5:0] rd_addr;
  logic       out_last;
  logic [7:0] frames_done;

  int checks;
  int failures;

  fft_pingpong_ctrl #(
    .DEPTH(64),
    .AW   (6)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .out_last   (out_last),
    .frames_done(frames_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input int cnt);
    logic [5:0] c;
    logic [5:0] r;
    c = 6'(cnt);
`ifdef FFT_BITREV_EN
    for (int b = 0; b < 6; b++) r[b] = c[5 - b];
`else
    r = c;
`endif
    return 32'(r);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_frames_done"}, 32'(frames_done), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    nrst      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // 1. Reset
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    chk_reset_outputs("reset");
    tick();

    // 2. Fill bank 0; readable only from the cycle after the last pair
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("fill0_wr_en", 32'(wr_en), 32'd1);
      chk("fill0_wr_addr", 32'(wr_addr), 32'(2 * i));
      chk("fill0_out_valid", 32'(out_valid), 32'd0);
      tick();
    end
    #1;
    chk("full0_out_valid", 32'(out_valid), 32'd1);
    chk("full0_rd_bank", 32'(rd_bank), 32'd0);
    chk("full0_rd_addr", 32'(rd_addr), exp_rd(0));
    chk("fill1_wr_en", 32'(wr_en), 32'd2);
    chk("fill1_wr_addr", 32'(wr_addr), 32'd0);
    tick();

    // 3. Drain bank 0
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("drain0_out_valid", 32'(out_valid), 32'd1);
      chk("drain0_rd_addr", 32'(rd_addr), exp_rd(i));
      chk("drain0_out_last", 32'(out_last), 32'(i == 63));
      tick();
    end
    #1;
    chk("drain0_frames_done", 32'(frames_done), 32'd1);
    chk("drain0_rd_bank", 32'(rd_bank), 32'd1);
    chk("drain0_fill_bank_invalid", 32'(out_valid), 32'd0);
    tick();

    // 6a. Nine more pairs into bank 1 (ten in the frame), then flush
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i < 10; i++) begin
      #1;
      chk("pre_flush_wr_en", 32'(wr_en), 32'd2);
      chk("pre_flush_wr_addr", 32'(wr_addr), 32'(2 * i));
      tick();
    end
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_wr_en", 32'(wr_en), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("post_flush_frames_done", 32'(frames_done), 32'd1);
    chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    chk("post_flush_rd_bank", 32'(rd_bank), 32'd0);
    chk("post_flush_wr_en", 32'(wr_en), 32'd1);
    chk("post_flush_wr_addr", 32'(wr_addr), 32'd0);
    tick();

    // 4. Backpressure: finish bank 0, fill bank 1, with no reads
    for (int i = 1; i < 32; i++) begin
      #1;
      chk("bp_fill0_wr_en", 32'(wr_en), 32'd1);
      chk("bp_fill0_wr_addr", 32'(wr_addr), 32'(2 * i));
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("bp_fill1_wr_en", 32'(wr_en), 32'd2);
      chk("bp_fill1_wr_addr", 32'(wr_addr), 32'(2 * i));
      chk("bp_fill1_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    #1;
    chk("bp_both_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_both_full_wr_en", 32'(wr_en), 32'd0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("bp_first_rd_bank", 32'(rd_bank), 32'd0);
    chk("bp_first_rd_addr", 32'(rd_addr), exp_rd(0));
    tick();
    for (int i = 1; i < 64; i++) begin
      #1;
      chk("bp_drain_in_ready", 32'(in_ready), 32'd0);
      chk("bp_drain_rd_addr", 32'(rd_addr), exp_rd(i));
      chk("bp_drain_out_last", 32'(out_last), 32'(i == 63));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("bp_freed_in_ready", 32'(in_ready), 32'd1);
    chk("bp_freed_wr_en", 32'(wr_en), 32'd1);
    chk("bp_freed_wr_addr", 32'(wr_addr), 32'd0);
    chk("bp_freed_frames_done", 32'(frames_done), 32'd2);
    chk("bp_freed_rd_bank", 32'(rd_bank), 32'd1);
    chk("bp_freed_out_valid", 32'(out_valid), 32'd1);
    tick();

    // 6b. Partial drain of bank 1, then asynchronous reset mid-frame
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("mid_drain_rd_bank", 32'(rd_bank), 32'd1);
      chk("mid_drain_rd_addr", 32'(rd_addr), exp_rd(i));
      chk("mid_drain_out_last", 32'(out_last), 32'd0);
      tick();
    end
    out_ready = 1'b0;
    #1;
    nrst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    nrst = 1'b1;
    #1;
    chk_reset_outputs("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
